// File: rtl/led_pattern_sequencer_pkg.sv
// led_pat_pkg: shared FSM encoding and widths for the LED pattern sequencer
package led_pat_pkg;
  localparam int SLOTS = 8;
  localparam int CODE_W = 2;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECORD = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;
endpackage

// File: rtl/led_pattern_sequencer_if.sv
// led_pattern_sequencer_if: mode/button controls in, slot codes and mux select out
interface led_pattern_sequencer_if;
  import led_pat_pkg::*;
  logic rec_en;
  logic play_en;
  logic clear;
  logic btn_valid;
  logic [CODE_W-1:0] btn_code;
  logic [CODE_W-1:0] slot0, slot1, slot2, slot3, slot4, slot5, slot6, slot7;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] count;
  logic full;
  logic playing;
  logic done;
  modport master (
    output rec_en, play_en, clear, btn_valid, btn_code,
    input slot0, slot1, slot2, slot3, slot4, slot5, slot6, slot7, sel, count, full, playing, done
  );
  modport slave (
    input rec_en, play_en, clear, btn_valid, btn_code,
    output slot0, slot1, slot2, slot3, slot4, slot5, slot6, slot7, sel, count, full, playing, done
  );
endinterface

// File: rtl/led_pattern_sequencer_tick_gen.sv
// led_tick_gen: one-cycle tick every TICK_DIV enabled cycles; counter restarts whenever en drops
module led_tick_gen #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TICK_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  logic [TICK_W-1:0] cnt;
  assign tick = en && cnt == TICK_W'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (en && !tick) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: records LED codes into 8 slots and drives the 8:1 mux select for preview/playback.
// Define LED_PAT_LOOP_EN for looping playback; otherwise playback runs once and pulses done.
module led_pattern_sequencer
  import led_pat_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int TICK_W = 26
) (
  input logic clk,
  input logic rst,
  led_pattern_sequencer_if.slave bus
);
`ifdef LED_PAT_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif
  logic [1:0] state;
  logic [CODE_W-1:0] slot [SLOTS];
  logic [CNT_W-1:0] count;
  logic [SEL_W-1:0] step;
  logic done, hold, tick, full, last, finish;
  led_tick_gen #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) u_tick (
    .clk(clk),
    .rst(rst),
    .en(state == PLAY),
    .tick(tick)
  );
  assign full = count == CNT_W'(SLOTS);
  assign last = step == SEL_W'(count - 1'b1);
  assign finish = state == PLAY && tick && last && bus.play_en && !bus.rec_en && !bus.clear;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      step <= '0;
      done <= 1'b0;
      hold <= 1'b0;
    end else begin
      done <= finish && !LOOP;
      // after a one-shot run, replay waits until play_en has been released
      hold <= !LOOP && bus.play_en && (hold || finish);
      if (bus.clear) begin
        state <= IDLE;
        step <= '0;
      end else if (state == IDLE)
        state <= bus.rec_en ? RECORD : (bus.play_en && count != '0 && !hold) ? PLAY : IDLE;
      else if (state == RECORD)
        state <= bus.rec_en ? RECORD : IDLE;
      else if (!bus.play_en || bus.rec_en) begin
        state <= IDLE;
        step <= '0;
      end else if (finish) begin
        state <= LOOP ? PLAY : IDLE;
        step <= '0;
      end else if (tick)
        step <= step + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      slot <= '{default: '0};
    end else if (bus.clear) begin
      count <= '0;
      slot <= '{default: '0};
    end else if (state == RECORD && bus.btn_valid && !full) begin
      slot[count[SEL_W-1:0]] <= bus.btn_code;
      count <= count + 1'b1;
    end
  // the mux maps sel=k to in(k-1), so slot index i is selected by i+1
  assign bus.sel = state == PLAY ? step + 1'b1 : count[SEL_W-1:0];
  assign bus.count = count;
  assign bus.full = full;
  assign bus.playing = state == PLAY;
  assign bus.done = done;
  assign bus.slot0 = slot[0];
  assign bus.slot1 = slot[1];
  assign bus.slot2 = slot[2];
  assign bus.slot3 = slot[3];
  assign bus.slot4 = slot[4];
  assign bus.slot5 = slot[5];
  assign bus.slot6 = slot[6];
  assign bus.slot7 = slot[7];
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed stimulus with a queued-expectation scoreboard checked each negedge
module tb_led_pattern_sequencer;
  typedef struct {
    int cyc;
    string name;
    logic [2:0] sel;
    logic [3:0] count;
    logic full;
    logic playing;
    logic done;
    logic [15:0] slots;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  logic [1:0] codes [9] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3};
  led_pattern_sequencer_if bus ();
  led_pattern_sequencer #(.TICK_DIV(4), .TICK_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string name, input logic [2:0] s, input logic [3:0] c,
                            input logic f, input logic p, input logic d, input logic [15:0] sl);
    exp_t e;
    e.cyc = cyc;
    e.name = name;
    e.sel = s;
    e.count = c;
    e.full = f;
    e.playing = p;
    e.done = d;
    e.slots = sl;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] act;
      e = q.pop_front();
      act = {bus.slot7, bus.slot6, bus.slot5, bus.slot4, bus.slot3, bus.slot2, bus.slot1, bus.slot0};
      checks++;
      if (e.cyc != cyc || bus.sel !== e.sel || bus.count !== e.count || bus.full !== e.full ||
          bus.playing !== e.playing || bus.done !== e.done || act !== e.slots) begin
        failures++;
        $display("FAIL %s cyc=%0d: got sel=%0d count=%0d full=%b playing=%b done=%b slots=%h; expected sel=%0d count=%0d full=%b playing=%b done=%b slots=%h (due cyc %0d)",
                 e.name, cyc, bus.sel, bus.count, bus.full, bus.playing, bus.done, act,
                 e.sel, e.count, e.full, e.playing, e.done, e.slots, e.cyc);
      end
    end
  end
  initial begin
    bus.rec_en = 1'b0;
    bus.play_en = 1'b0;
    bus.clear = 1'b0;
    bus.btn_valid = 1'b0;
    bus.btn_code = 2'd0;
    tick();
    tick();
    expect_out("reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    bus.play_en = 1'b1;
    tick();
    expect_out("play_empty0", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("play_empty1", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    bus.play_en = 1'b0;
    bus.rec_en = 1'b1;
    tick();
    bus.btn_valid = 1'b1;
    bus.btn_code = 2'd1;
    tick();
    expect_out("rec1", 3'd1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0001);
    bus.btn_code = 2'd2;
    tick();
    expect_out("rec2", 3'd2, 4'd2, 1'b0, 1'b0, 1'b0, 16'h0009);
    bus.btn_code = 2'd3;
    tick();
    expect_out("rec3", 3'd3, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0039);
    bus.btn_valid = 1'b0;
    bus.rec_en = 1'b0;
    tick();
    expect_out("idle3", 3'd3, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0039);
    bus.btn_valid = 1'b1;
    bus.btn_code = 2'd2;
    tick();
    expect_out("btn_in_idle", 3'd3, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0039);
    bus.btn_valid = 1'b0;
    bus.play_en = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      expect_out($sformatf("play%0d", k), 3'(1 + k / 4), 4'd3, 1'b0, 1'b1, 1'b0, 16'h0039);
      tick();
    end
`ifdef LED_PAT_LOOP_EN
    for (int k = 0; k < 4; k++) begin
      expect_out($sformatf("loop%0d", k), 3'd1, 4'd3, 1'b0, 1'b1, 1'b0, 16'h0039);
      tick();
    end
    bus.play_en = 1'b0;
    tick();
    expect_out("stop", 3'd3, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0039);
`else
    expect_out("done", 3'd3, 4'd3, 1'b0, 1'b0, 1'b1, 16'h0039);
    tick();
    expect_out("after_done", 3'd3, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0039);
    tick();
    expect_out("no_replay", 3'd3, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0039);
    bus.play_en = 1'b0;
    tick();
    expect_out("idle_after", 3'd3, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0039);
`endif
    bus.play_en = 1'b1;
    tick();
    tick();
    tick();
    expect_out("mid_play", 3'd1, 4'd3, 1'b0, 1'b1, 1'b0, 16'h0039);
    tick();
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    bus.play_en = 1'b0;
    tick();
    rst = 1'b0;
    bus.rec_en = 1'b1;
    tick();
    bus.btn_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.btn_code = codes[i];
      tick();
    end
    bus.btn_valid = 1'b0;
    expect_out("full", 3'd0, 4'd8, 1'b1, 1'b0, 1'b0, 16'h9B39);
    bus.clear = 1'b1;
    bus.btn_valid = 1'b1;
    bus.btn_code = 2'd3;
    tick();
    expect_out("clear_full", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    bus.clear = 1'b0;
    bus.btn_valid = 1'b0;
    tick();
    bus.btn_valid = 1'b1;
    bus.btn_code = 2'd2;
    tick();
    expect_out("rec_after_clear", 3'd1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0002);
    bus.clear = 1'b1;
    bus.btn_code = 2'd3;
    tick();
    expect_out("clear_with_btn", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    bus.clear = 1'b0;
    bus.rec_en = 1'b0;
    bus.btn_code = 2'd1;
    tick();
    expect_out("clear_forces_idle", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    bus.btn_valid = 1'b0;
    tick();
    tick();
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
